rr_mux8: RTL and testbench



---
 rtl/rr_mux8_pkg.sv | 11 +
 rtl/rr_mux8_pick.sv | 38 +++
 rtl/rr_mux8.sv | 97 +++++++++
 tb/tb_rr_mux8.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux8_pkg.sv
// rr_mux8_pkg: shared constants for the round-robin collecting multiplexer.
//   N_LANES : number of input lanes (power of two, >= 2)
//   SEL_W   : width of a lane index, log2(N_LANES)
//   PTR_RST : pointer value after reset; N_LANES-1 so the first scan starts at lane 0
package rr_mux8_pkg;

  localparam int N_LANES = 8;
  localparam int SEL_W   = 3;
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(N_LANES - 1);

endpackage : rr_mux8_pkg

// File: rtl/rr_mux8_pick.sv
// rr_pick: combinational rotate/priority-find for the round-robin arbiter.
// Finds the first set bit of pending searching ptr+1, ptr+2, ... modulo N.
// Ports:
//   pending [N-1:0]    in  : lanes currently holding a post
//   ptr     [SELW-1:0] in  : last granted lane
//   grant   [SELW-1:0] out : index of the chosen lane (0 when none found)
//   found              out : at least one pending lane exists
module rr_pick
  import rr_mux8_pkg::*;
#(
  parameter int N    = N_LANES,
  parameter int SELW = SEL_W
) (
  input  logic [N-1:0]    pending,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            found
);

  logic [SELW-1:0] idx;

  // Walk the search order backwards so the nearest lane after ptr is the
  // last assignment and therefore wins. Index arithmetic wraps naturally
  // because N is a power of two; offset N lands on ptr itself, last in line.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = ptr + SELW'(k);
      if (pending[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_mux8.sv
// rr_mux8: round-robin N-to-1 collecting multiplexer.
// Each lane posts one data bit with a request strobe; posts are latched and
// forwarded one lane per cycle on a serial output tagged with the lane index.
// Ports:
//   clk              in  : rising-edge clock
//   rst              in  : synchronous active-high reset
//   en               in  : scan enable (0 freezes granting, latching continues)
//   req     [N-1:0]  in  : per-lane request strobe
//   in      [N-1:0]  in  : per-lane data bit, captured with req
//   out              out : forwarded data bit of the granted lane
//   sel     [SELW-1:0] out : index of the granted lane
//   valid            out : out/sel carry a grant this cycle
//   pending [N-1:0]  out : lanes latched and not yet granted
//   overrun          out : sticky, a lane was re-posted while still pending
module rr_mux8
  import rr_mux8_pkg::*;
#(
  parameter int N    = N_LANES,
  parameter int SELW = SEL_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    in,
  output logic            out,
  output logic [SELW-1:0] sel,
  output logic            valid,
  output logic [N-1:0]    pending,
  output logic            overrun
);

  logic [N-1:0]    pending_reg, pending_next;
  logic [N-1:0]    data_reg, data_next;
  logic [SELW-1:0] ptr_reg;
  logic [SELW-1:0] sel_reg;
  logic            out_reg;
  logic            valid_reg;
  logic            overrun_reg, overrun_next;

  logic [SELW-1:0] grant;
  logic            found;
  logic            grant_hit;
  logic [N-1:0]    grant_mask;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .pending (pending_reg),
    .ptr     (ptr_reg),
    .grant   (grant),
    .found   (found)
  );

  assign grant_hit = en && found;

  // Per-lane latch: a new post always wins over the grant clearing the lane,
  // so a same-edge grant and re-post forwards the old bit and keeps the new one.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign grant_mask[gi]   = grant_hit && (grant == SELW'(gi));
    assign pending_next[gi] = req[gi] | (pending_reg[gi] & ~grant_mask[gi]);
    assign data_next[gi]    = req[gi] ? in[gi] : data_reg[gi];
  end

  // Overrun only when a still-pending post is overwritten without being consumed.
  assign overrun_next = overrun_reg | (|(req & pending_reg & ~grant_mask));

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
      data_reg    <= '0;
      ptr_reg     <= PTR_RST;
      sel_reg     <= '0;
      out_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      data_reg    <= data_next;
      overrun_reg <= overrun_next;
      valid_reg   <= grant_hit;
      if (grant_hit) begin
        out_reg <= data_reg[grant];
        sel_reg <= grant;
        ptr_reg <= grant;
      end
    end
  end

  assign out     = out_reg;
  assign sel     = sel_reg;
  assign valid   = valid_reg;
  assign pending = pending_reg;
  assign overrun = overrun_reg;

endmodule : rr_mux8

// File: tb/tb_rr_mux8.sv
// tb_rr_mux8: directed self-checking bench for rr_mux8.
module tb_rr_mux8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] in;
  logic       out;
  logic [2:0] sel;
  logic       valid;
  logic [7:0] pending;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  rr_mux8 dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .in      (in),
    .out     (out),
    .sel     (sel),
    .valid   (valid),
    .pending (pending),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Advance one edge; sample and drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    in  = 8'h00;
    en  = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    req = 8'h00;
    in  = 8'h00;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    $display("txn reset: valid=%0d sel=%0d pending=%02h", valid, sel, pending);

    // Single post on lane 0
    req = 8'h01; in = 8'h01;
    tick();
    req = 8'h00; in = 8'h00;
    chk("t1_latch_pending", 32'(pending), 32'h01);
    chk("t1_latch_valid", 32'(valid), 32'd0);
    tick();
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_sel", 32'(sel), 32'd0);
    chk("t1_out", 32'(out), 32'd1);
    $display("txn lane0: valid=%0d sel=%0d out=%0d", valid, sel, out);
    tick();
    chk("t1_idle_valid", 32'(valid), 32'd0);
    chk("t1_idle_pending", 32'(pending), 32'd0);

    // All lanes at once
    do_reset();
    req = 8'hFF; in = 8'b1010_1010;
    tick();
    req = 8'h00; in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t2_valid_%0d", i), 32'(valid), 32'd1);
      chk($sformatf("t2_sel_%0d", i), 32'(sel), 32'(i));
      chk($sformatf("t2_out_%0d", i), 32'(out), 32'(i % 2));
      $display("txn all: valid=%0d sel=%0d out=%0d", valid, sel, out);
    end
    tick();
    chk("t2_done_valid", 32'(valid), 32'd0);
    chk("t2_done_pending", 32'(pending), 32'd0);

    // Wrap/fairness: set ptr=5 via a lane-5 grant, then lanes 6 and 1 post continuously
    do_reset();
    req = 8'h20; in = 8'h00;
    tick();
    req = 8'h00;
    tick();
    chk("t3_ptr_sel", 32'(sel), 32'd5);
    req = 8'b0100_0010; in = 8'b0100_0010;
    tick();
    chk("t3_latch_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t3_valid_%0d", i), 32'(valid), 32'd1);
      chk($sformatf("t3_sel_%0d", i), 32'(sel), (i % 2 == 0) ? 32'd6 : 32'd1);
      $display("txn wrap: valid=%0d sel=%0d", valid, sel);
    end
    req = 8'h00; in = 8'h00;

    // Overrun: post lane 3 with en=0, re-post with in=0
    do_reset();
    en = 1'b0;
    req = 8'h08; in = 8'h08;
    tick();
    chk("t4_first_overrun", 32'(overrun), 32'd0);
    req = 8'h08; in = 8'h00;
    tick();
    req = 8'h00;
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_pending3", 32'(pending[3]), 32'd1);
    chk("t4_hold_valid", 32'(valid), 32'd0);
    en = 1'b1;
    tick();
    chk("t4_valid", 32'(valid), 32'd1);
    chk("t4_sel", 32'(sel), 32'd3);
    chk("t4_out", 32'(out), 32'd0);
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);
    $display("txn overrun: sel=%0d out=%0d overrun=%0d", sel, out, overrun);

    // Same-edge grant and re-post on lane 2
    do_reset();
    req = 8'h04; in = 8'h00;
    tick();
    req = 8'h04; in = 8'h04;
    tick();
    req = 8'h00; in = 8'h00;
    chk("t5_g1_valid", 32'(valid), 32'd1);
    chk("t5_g1_sel", 32'(sel), 32'd2);
    chk("t5_g1_out", 32'(out), 32'd0);
    chk("t5_g1_pending", 32'(pending), 32'h04);
    chk("t5_g1_overrun", 32'(overrun), 32'd0);
    tick();
    chk("t5_g2_valid", 32'(valid), 32'd1);
    chk("t5_g2_sel", 32'(sel), 32'd2);
    chk("t5_g2_out", 32'(out), 32'd1);
    chk("t5_g2_overrun", 32'(overrun), 32'd0);
    $display("txn same_edge: sel=%0d out=%0d overrun=%0d", sel, out, overrun);

    // en=0 freeze mid-stream: lanes 0 and 1 pending, freeze after first grant
    do_reset();
    req = 8'h03; in = 8'h03;
    tick();
    req = 8'h00; in = 8'h00;
    tick();
    chk("t6_first_sel", 32'(sel), 32'd0);
    en = 1'b0;
    tick();
    chk("t6_frozen_valid", 32'(valid), 32'd0);
    chk("t6_frozen_sel", 32'(sel), 32'd0);
    chk("t6_frozen_out", 32'(out), 32'd1);
    chk("t6_frozen_pending", 32'(pending), 32'h02);
    en = 1'b1;
    tick();
    chk("t6_resume_valid", 32'(valid), 32'd1);
    chk("t6_resume_sel", 32'(sel), 32'd1);
    $display("txn freeze: valid=%0d sel=%0d", valid, sel);

    // Reset mid-stream with 5 lanes pending
    do_reset();
    req = 8'h1F; in = 8'h1F;
    tick();
    req = 8'h00; in = 8'h00;
    tick();
    chk("t7_pre_pending", 32'(pending), 32'h1E);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_valid", 32'(valid), 32'd0);
    chk("t7_pending", 32'(pending), 32'd0);
    chk("t7_sel", 32'(sel), 32'd0);
    chk("t7_overrun", 32'(overrun), 32'd0);
    req = 8'h10; in = 8'h10;
    tick();
    req = 8'h00; in = 8'h00;
    tick();
    chk("t7_post_valid", 32'(valid), 32'd1);
    chk("t7_post_sel", 32'(sel), 32'd4);
    chk("t7_post_out", 32'(out), 32'd1);
    $display("txn reset_mid: valid=%0d sel=%0d", valid, sel);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rr_mux8
